inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Consumer end of the PC register: reads the 32-bit PC, fetches the instruction
//  over the byte-wide memory port (4 sequential byte reads), presents it to IF/ID,
//  and drives the stall request that freezes the PC while a fetch is in progress.
//  Sits between the PC register, the memory arbiter and the IF/ID pipeline register.
// PARAMETERS
//  MEM_LAT  1  cycles from accepted byte request to valid mem_rdata_i (1..4)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, synchronous, active-high
//  pc_i         in   32  current PC from PC register
//  stall_i      in   1   IF/ID stalled (stall[1]); holds presented instruction
//  flush_i      in   1   taken branch/jump (ID or EX); abort current fetch
//  mem_req_o    out  1   byte read request
//  mem_addr_o   out  32  byte address of request
//  mem_grant_i  in   1   arbiter accepts request this cycle (req && grant)
//  mem_rdata_i  in   8   read byte, valid exactly MEM_LAT cycles after acceptance
//  if_pc_o      out  32  PC of presented instruction
//  if_inst_o    out  32  presented instruction
//  if_valid_o   out  1   if_pc_o/if_inst_o valid
//  stall_req_o  out  1   to stall controller; 1 = freeze PC (drives stall[0])
// BEHAVIOUR
//  - States IDLE, FETCH, DONE. rst: state IDLE, fetch_pc/if_pc_o/if_inst_o = 0,
//    if_valid_o=0, mem_req_o=0, issue/receive counters 0, latency pipe cleared.
//  - IDLE (1 cycle): fetch_pc <= pc_i, counters <= 0, -> FETCH.
//  - FETCH: mem_req_o=1 while issued<4; mem_addr_o = fetch_pc + issued (mod 2^32,
//    no alignment check). issued increments only on mem_req_o && mem_grant_i;
//    grant low = pause, no byte lost or repeated.
//  - Each accepted request enters a MEM_LAT-deep pipe tagged {byte_idx, epoch}.
//    Returning byte k goes to inst[8k+7:8k] (little-endian) if tag epoch == epoch.
//  - Byte 3 received in current epoch -> DONE; if_inst_o/if_pc_o registered,
//    if_valid_o=1 from first DONE cycle.
//  - DONE: mem_req_o=0; outputs held stable. stall_i=0: instruction consumed and
//    PC advances at this edge, -> IDLE (if_valid_o <= 0). stall_i=1: stay DONE.
//  - stall_req_o = (state != DONE) && !flush_i  (combinational).
//  - flush_i (priority over stall_i and grant, any state): epoch toggles,
//    counters <= 0, if_valid_o <= 0, -> IDLE; mem_req_o forced 0 in flush cycle;
//    stall_req_o low so PC register loads the target at this edge. In-flight stale
//    bytes arriving later are discarded.
//  - Latency IDLE -> DONE with constant grant = 5 + MEM_LAT cycles.
//  - rst mid-fetch: pipe cleared; bytes returned after reset ignored.
// TESTING
//  1 MEM_LAT=1, grant=1, mem[0..3]=13 05 10 00 -> addrs 0,1,2,3 in cycles 1-4,
//    DONE cycle 6: if_inst_o=0x00100513, if_pc_o=0; next IDLE captures pc_i=4.
//  2 As 1, grant=0 in cycles 2-3 -> addrs 0,1,1(hold),1(hold),2,3; DONE cycle 8,
//    same instruction.
//  3 flush_i in cycle 3 (bytes 0,1 in flight), pc_i then 0x100 -> stale bytes
//    dropped, next fetch from 0x100..0x103, if_pc_o=0x100.
//  4 stall_i=1 for 3 cycles in DONE -> outputs stable, mem_req_o=0,
//    stall_req_o=0; one consume, then IDLE.
//  5 rst asserted during FETCH with MEM_LAT=3 -> all outputs 0 next cycle,
//    returning bytes ignored, fetch restarts at pc_i=0.
//  6 pc_i=0xFFFFFFFE -> mem_addr_o FFFFFFFE, FFFFFFFF, 00000000, 00000001.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: builds a 32-bit instruction from four sequential byte reads at the PC,
// presents it to IF/ID and holds the PC frozen while the fetch is outstanding.
module inst_fetch_unit #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_grant_i,
  input  logic [7:0]  mem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o,
  output logic        stall_req_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] fetch_pc_q;
  logic [2:0]  issued_q;
  logic        epoch_q;
  logic [23:0] inst_lo_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_inst_q;
  logic        if_valid_q;

  logic [MEM_LAT-1:0]      pipe_v_q;
  logic [MEM_LAT-1:0]      pipe_ep_q;
  logic [MEM_LAT-1:0][1:0] pipe_idx_q;

  logic       accept_d;
  logic       ret_ok_d;
  logic [1:0] ret_idx_d;

  assign mem_req_o   = (state_q == S_FETCH) && (issued_q < 3'd4) && !flush_i;
  assign mem_addr_o  = fetch_pc_q + {29'd0, issued_q};
  assign stall_req_o = (state_q != S_DONE) && !flush_i;
  assign if_pc_o     = if_pc_q;
  assign if_inst_o   = if_inst_q;
  assign if_valid_o  = if_valid_q;

  assign accept_d  = mem_req_o && mem_grant_i;
  assign ret_idx_d = pipe_idx_q[MEM_LAT-1];
  // Bytes belonging to an aborted fetch carry the old epoch and are dropped.
  assign ret_ok_d  = pipe_v_q[MEM_LAT-1] && (pipe_ep_q[MEM_LAT-1] == epoch_q) &&
                     (state_q == S_FETCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v_q   <= '0;
      pipe_ep_q  <= '0;
      pipe_idx_q <= '0;
    end else begin
      pipe_v_q[0]   <= accept_d;
      pipe_ep_q[0]  <= epoch_q;
      pipe_idx_q[0] <= issued_q[1:0];
      for (int k = 1; k < MEM_LAT; k++) begin
        pipe_v_q[k]   <= pipe_v_q[k-1];
        pipe_ep_q[k]  <= pipe_ep_q[k-1];
        pipe_idx_q[k] <= pipe_idx_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= 32'd0;
      issued_q   <= 3'd0;
      epoch_q    <= 1'b0;
      inst_lo_q  <= 24'd0;
      if_pc_q    <= 32'd0;
      if_inst_q  <= 32'd0;
      if_valid_q <= 1'b0;
    end else if (flush_i) begin
      epoch_q    <= ~epoch_q;
      issued_q   <= 3'd0;
      if_valid_q <= 1'b0;
      state_q    <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          fetch_pc_q <= pc_i;
          issued_q   <= 3'd0;
          inst_lo_q  <= 24'd0;
          state_q    <= S_FETCH;
        end
        S_FETCH: begin
          if (accept_d) begin
            issued_q <= issued_q + 3'd1;
          end
          if (ret_ok_d) begin
            case (ret_idx_d)
              2'd0: inst_lo_q[7:0]   <= mem_rdata_i;
              2'd1: inst_lo_q[15:8]  <= mem_rdata_i;
              2'd2: inst_lo_q[23:16] <= mem_rdata_i;
              default: begin
                if_inst_q  <= {mem_rdata_i, inst_lo_q};
                if_pc_q    <= fetch_pc_q;
                if_valid_q <= 1'b1;
                state_q    <= S_DONE;
              end
            endcase
          end
        end
        S_DONE: begin
          if (!stall_i) begin
            if_valid_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: begin
          if_valid_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: two instances (MEM_LAT 1 and 3) share stimulus; a transaction-level
// model checks every cycle, directed cases pin literal values.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'd0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        grant = 1'b1;

  logic        req    [2];
  logic [31:0] addr   [2];
  logic [7:0]  rdata  [2];
  logic [31:0] ipc    [2];
  logic [31:0] iinst  [2];
  logic        ivalid [2];
  logic        sreq   [2];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.MEM_LAT(1)) u0 (
    .clk(clk), .rst(rst), .pc_i(pc), .stall_i(stall), .flush_i(flush),
    .mem_req_o(req[0]), .mem_addr_o(addr[0]), .mem_grant_i(grant), .mem_rdata_i(rdata[0]),
    .if_pc_o(ipc[0]), .if_inst_o(iinst[0]), .if_valid_o(ivalid[0]), .stall_req_o(sreq[0])
  );

  inst_fetch_unit #(.MEM_LAT(3)) u1 (
    .clk(clk), .rst(rst), .pc_i(pc), .stall_i(stall), .flush_i(flush),
    .mem_req_o(req[1]), .mem_addr_o(addr[1]), .mem_grant_i(grant), .mem_rdata_i(rdata[1]),
    .if_pc_o(ipc[1]), .if_inst_o(iinst[1]), .if_valid_o(ivalid[1]), .stall_req_o(sreq[1])
  );

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 8'h13;
      32'h0000_0001: return 8'h05;
      32'h0000_0002: return 8'h10;
      32'h0000_0003: return 8'h00;
      default:       return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Memory side: an accepted byte request returns its data exactly MEM_LAT cycles later.
  logic        acc_v [2];
  logic [31:0] acc_a [2];
  logic        dv    [2][4];
  logic [31:0] da    [2][4];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      dv[i][0] <= acc_v[i];
      da[i][0] <= acc_a[i];
      for (int k = 1; k < 4; k++) begin
        dv[i][k] <= dv[i][k-1];
        da[i][k] <= da[i][k-1];
      end
    end
  end

  assign rdata[0] = dv[0][0] ? mem_byte(da[0][0]) : 8'hEE;
  assign rdata[1] = dv[1][2] ? mem_byte(da[1][2]) : 8'hEE;

  // Transaction model: phase 0 = capturing PC, 1 = issuing/awaiting bytes, 2 = presenting.
  int          ph      [2];
  int          nacc    [2];
  int          done_at [2];
  logic [31:0] fpc     [2];
  logic [31:0] e_pc    [2];
  logic [31:0] e_inst  [2];
  bit          on      [2];
  logic        m_req;
  int          gcyc = 0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      on[i] = 1'b0; ph[i] = 0; nacc[i] = 0; done_at[i] = 0;
      fpc[i] = 32'd0; e_pc[i] = 32'd0; e_inst[i] = 32'd0;
      acc_v[i] = 1'b0; acc_a[i] = 32'd0;
    end
    forever begin
      @(negedge clk);
      gcyc++;
      for (int i = 0; i < 2; i++) begin
        acc_v[i] = req[i] && grant;
        acc_a[i] = addr[i];
        if (rst) begin
          ph[i] = 0; nacc[i] = 0; e_pc[i] = 32'd0; e_inst[i] = 32'd0; on[i] = 1'b1;
        end else if (on[i]) begin
          m_req = (ph[i] == 1) && (nacc[i] < 4) && !flush;
          chk($sformatf("u%0d.req", i), 32'(req[i]), 32'(m_req));
          if (m_req) chk($sformatf("u%0d.addr", i), addr[i], fpc[i] + 32'(nacc[i]));
          chk($sformatf("u%0d.valid", i), 32'(ivalid[i]), 32'(ph[i] == 2));
          chk($sformatf("u%0d.stall_req", i), 32'(sreq[i]), 32'((ph[i] != 2) && !flush));
          chk($sformatf("u%0d.if_pc", i), ipc[i], e_pc[i]);
          chk($sformatf("u%0d.if_inst", i), iinst[i], e_inst[i]);
          if (flush) begin
            ph[i] = 0;
          end else if (ph[i] == 0) begin
            fpc[i] = pc; nacc[i] = 0; ph[i] = 1;
          end else if (ph[i] == 1) begin
            if (req[i] && grant && nacc[i] < 4) begin
              nacc[i]++;
              if (nacc[i] == 4) done_at[i] = gcyc + lat_of(i) + 1;
            end
            if (nacc[i] == 4 && gcyc + 1 == done_at[i]) begin
              ph[i] = 2; e_pc[i] = fpc[i]; e_inst[i] = mem_word(fpc[i]);
            end
          end else if (!stall) begin
            ph[i] = 0;
          end
        end
      end
    end
  end

  task automatic begin_test(input logic [31:0] p);
    @(posedge clk); #1;
    rst = 1'b1; flush = 1'b0; stall = 1'b0; grant = 1'b1; pc = p;
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; stall = 1'b0; grant = 1'b1;
  endtask

  logic [15:0] gpat;
  logic [10:0] spat;

  initial begin
    // 1: basic fetch at PC 0, then the next IDLE captures PC 4
    begin_test(32'd0);
    for (int c = 0; c < 10; c++) begin
      step();
      pc = (c >= 7) ? 32'd4 : 32'd0;
      @(negedge clk);
      if (c == 0) chk("t1.req_idle", 32'(req[0]), 32'd0);
      if (c >= 1 && c <= 4) chk("t1.addr", addr[0], 32'(c - 1));
      if (c == 5) chk("t1.req_off", 32'(req[0]), 32'd0);
      if (c == 5) chk("t1.valid_early", 32'(ivalid[0]), 32'd0);
      if (c == 6) chk("t1.valid", 32'(ivalid[0]), 32'd1);
      if (c == 6) chk("t1.inst", iinst[0], 32'h0010_0513);
      if (c == 6) chk("t1.pc", ipc[0], 32'd0);
      if (c == 7) chk("t1.valid_drop", 32'(ivalid[0]), 32'd0);
      if (c == 8) chk("t1.next_addr", addr[0], 32'd4);
    end

    // 2: grant low in cycles 2-3
    begin_test(32'd0);
    for (int c = 0; c < 10; c++) begin
      step();
      pc = 32'd0;
      grant = !(c == 2 || c == 3);
      @(negedge clk);
      if (c == 2 || c == 3 || c == 4) chk("t2.hold_addr", addr[0], 32'd1);
      if (c == 5) chk("t2.addr2", addr[0], 32'd2);
      if (c == 6) chk("t2.addr3", addr[0], 32'd3);
      if (c == 7) chk("t2.valid_early", 32'(ivalid[0]), 32'd0);
      if (c == 8) chk("t2.inst", iinst[0], 32'h0010_0513);
    end

    // 3: flush in cycle 3, branch target 0x100
    begin_test(32'd0);
    for (int c = 0; c < 14; c++) begin
      step();
      pc = (c >= 4) ? 32'h100 : 32'd0;
      flush = (c == 3);
      @(negedge clk);
      if (c == 3) chk("t3.req_flush", 32'(req[0]), 32'd0);
      if (c == 3) chk("t3.stall_req_flush", 32'(sreq[0]), 32'd0);
      if (c == 5) chk("t3.addr_first", addr[0], 32'h100);
      if (c == 8) chk("t3.addr_last", addr[0], 32'h103);
      if (c == 10) chk("t3.pc", ipc[0], 32'h100);
      if (c == 10) chk("t3.inst", iinst[0], 32'h5859_5A5B);
      if (c == 12) chk("t3.u1_pc", ipc[1], 32'h100);
    end

    // 3b: flush while bytes 2,3 are still in flight on the slow instance
    begin_test(32'd0);
    for (int c = 0; c < 16; c++) begin
      step();
      pc = (c >= 6) ? 32'h200 : 32'd0;
      flush = (c == 5);
      @(negedge clk);
      if (c == 6) chk("t3b.u0_no_valid", 32'(ivalid[0]), 32'd0);
      if (c == 8) chk("t3b.u1_stale_drop", 32'(ivalid[1]), 32'd0);
      if (c == 14) chk("t3b.u1_valid", 32'(ivalid[1]), 32'd1);
      if (c == 14) chk("t3b.u1_inst", iinst[1], 32'h5B5A_5958);
    end

    // 4: IF/ID stalled for 3 cycles while presenting
    begin_test(32'd0);
    for (int c = 0; c < 12; c++) begin
      step();
      pc = (c >= 10) ? 32'd4 : 32'd0;
      stall = (c >= 6 && c <= 8);
      @(negedge clk);
      if (c >= 6 && c <= 9) begin
        chk("t4.valid", 32'(ivalid[0]), 32'd1);
        chk("t4.inst", iinst[0], 32'h0010_0513);
        chk("t4.req", 32'(req[0]), 32'd0);
        chk("t4.stall_req", 32'(sreq[0]), 32'd0);
      end
      if (c == 10) chk("t4.consumed", 32'(ivalid[0]), 32'd0);
    end

    // 5: reset during a slow fetch, stale bytes return afterwards
    begin_test(32'h40);
    for (int c = 0; c < 24; c++) begin
      step();
      pc = (c < 9) ? 32'h40 : ((c < 14) ? 32'h44 : 32'd0);
      rst = (c == 13);
      @(negedge clk);
      if (c == 8) chk("t5.pc_before", ipc[1], 32'h40);
      if (c == 10) chk("t5.addr", addr[1], 32'h44);
      if (c == 14) begin
        chk("t5.rst_valid", 32'(ivalid[1]), 32'd0);
        chk("t5.rst_req", 32'(req[1]), 32'd0);
        chk("t5.rst_pc", ipc[1], 32'd0);
        chk("t5.rst_inst", iinst[1], 32'd0);
      end
      if (c == 17) chk("t5.stale_ignored", 32'(ivalid[1]), 32'd0);
      if (c == 22) chk("t5.valid", 32'(ivalid[1]), 32'd1);
      if (c == 22) chk("t5.inst", iinst[1], 32'h0010_0513);
    end

    // 6: address wrap
    begin_test(32'hFFFF_FFFE);
    for (int c = 0; c < 8; c++) begin
      step();
      pc = 32'hFFFF_FFFE;
      @(negedge clk);
      if (c >= 1 && c <= 4) chk("t6.addr", addr[0], 32'hFFFF_FFFE + 32'(c - 1));
      if (c == 6) chk("t6.inst", iinst[0], 32'h0513_A5A4);
      if (c == 6) chk("t6.pc", ipc[0], 32'hFFFF_FFFE);
    end

    // 7: mixed grant/stall/flush pattern, checked by the model only
    gpat = 16'b1101_1011_0111_1010;
    spat = 11'b001_1000_0100;
    begin_test(32'h1000);
    for (int c = 0; c < 60; c++) begin
      step();
      pc = 32'h1000 + 32'(4 * c);
      grant = gpat[c % 16];
      stall = spat[c % 11];
      flush = (c == 23 || c == 41);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
